l1_trigger_queue: RTL and testbench
===================================

Name: l1_trigger_queue

Overview:
- Consumes the per-BC L1 trigger strobe from the trigger stage; stores one entry per trigger cycle in a small queue.
- Each entry is tagged with the L1 ID, the sub-trigger index within a multi-BC burst, and the BCID.
- Returns L1_Reg_Full to the trigger stage, which masks new triggers while it is high.
- Feeds the readout/data-formatter stage through a first-word-fall-through valid/ack interface.
- Control state is triple-redundant with majority voting (SEU tolerance); storage RAM is not.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2
BCID_W, 8, BCID width
L1ID_W, 5, L1 ID width
SUB_W, 4, sub-trigger index width (matches Trigger_Count width)

Ports:
Clk  in  1  system clock (BC); all logic on posedge
Reset  in  1  asynchronous, active-low
L1Trig_In  in  1  trigger strobe, high one cycle per triggered BC; consecutive high cycles = one burst
BCID_In  in  BCID_W  current bunch-crossing ID
L1_Reg_Full  out  1  queue full, combinational from voted count
L1_Reg_Empty  out  1  queue empty
Occupancy  out  log2(DEPTH)+1  voted entry count
Rd_Valid  out  1  head entry present (= !L1_Reg_Empty)
Rd_Ack  in  1  pop head; effective only with Rd_Valid
Rd_L1ID  out  L1ID_W  head L1 ID
Rd_Sub  out  SUB_W  head sub-trigger index
Rd_BCID  out  BCID_W  head BCID
Overflow_Err  out  1  sticky, set on dropped trigger
Err_Clear  in  1  synchronous clear of Overflow_Err

Behaviour:
- Reset (async, any time including mid-burst):
  - pointers, count, Next_ID, Cur_ID, Cur_Sub, Prev_Trig, Overflow_Err all cleared.
  - Queue contents are discarded.
  - Outputs after reset: L1_Reg_Empty=1, Rd_Valid=0, L1_Reg_Full=0, Occupancy=0, Overflow_Err=0.
  - Rd_* data outputs are 0 while Rd_Valid=0.
- TMR: write pointer, read pointer, count, Next_ID, Cur_ID, Cur_Sub, Prev_Trig and Overflow_Err are each held in 3 copies. Each bit is 2-of-3 majority voted. All next-state logic uses voted values; all three copies load the same next value.
- Burst detection: Start = L1Trig_In & !Prev_Trig; Prev_Trig <= L1Trig_In every cycle.
- Tagging, per cycle with L1Trig_In=1:
  - On Start: tag L1ID=Next_ID, Sub=0; Cur_ID <= Next_ID; Next_ID <= Next_ID+1 (wraps modulo 2^L1ID_W); Cur_Sub <= 0.
  - Otherwise: tag L1ID=Cur_ID, Sub=Cur_Sub+1 (wraps modulo 2^SUB_W); Cur_Sub <= Cur_Sub+1.
  - ID and sub counters advance even if the entry is dropped, so readout can see the gap.
- Push: L1Trig_In=1 and not full → write {L1ID, Sub, BCID_In} at the write pointer; write pointer +1 (mod DEPTH).
- Drop: L1Trig_In=1 while full (voted count==DEPTH) → no write; Overflow_Err <= 1.
  - Applies even if Rd_Ack pops in the same cycle; full is judged on the pre-edge count.
- Pop: Rd_Ack=1 and Rd_Valid=1 → read pointer +1. Rd_Ack while empty is ignored with no error.
- Simultaneous push and pop when not full: both happen, count unchanged.
- Count: +1 on push only, −1 on pop only. Stays within 0..DEPTH.
- Latency: entry written at posedge N appears at the head, with Rd_Valid=1, immediately after posedge N if the queue was empty. Push-to-visible latency is 1 edge.
- Full timing: L1_Reg_Full rises immediately after the edge that makes count==DEPTH. It falls after the first pop edge.
- Overflow_Err: cleared by Err_Clear at the next edge. If Err_Clear and a drop occur in the same cycle, set wins.
- Rd_* outputs are driven combinationally from the voted read pointer and storage.

Test Plan:
- Reset, then single 1-cycle trigger at BCID=0x10 → next cycle Rd_Valid=1, Rd_L1ID=0, Rd_Sub=0, Rd_BCID=0x10, Occupancy=1; Rd_Ack one cycle → Rd_Valid=0.
- 3-cycle burst at BCID 0x20..0x22, then a gap, then a 1-cycle trigger at 0x30 → entries (0,0,0x20), (0,1,0x21), (0,2,0x22), (1,0,0x30).
- DEPTH=4, Rd_Ack held low, 6-cycle burst → L1_Reg_Full=1 after the 4th edge; entries 5–6 dropped; Overflow_Err=1. Pop all → Sub 0..3. Next burst tagged L1ID=1, Sub=0.
- Push and pop every cycle for 20 cycles with Occupancy=1 → Occupancy stays 1; L1ID wraps 31→0 across 40 single-cycle bursts.
- Async Reset asserted mid-burst with Occupancy=3 → all outputs at reset values immediately. After release, the next trigger is tagged L1ID=0, Sub=0.
- Force one copy of the write pointer and one copy of Next_ID to corrupt values → outputs and tags unchanged; the corrupted copy resynchronizes at the next edge.

Source files
------------

// File: rtl/l1_trigger_queue.sv
// l1_trigger_queue: per-BC L1 trigger queue with burst tagging (L1 ID,
// sub-trigger index, BCID) and a first-word-fall-through readout port.
// All control state is kept in three copies and majority voted. The entry
// storage is a plain RAM with no redundancy and no reset.
module l1_trigger_queue #(
  parameter int DEPTH  = 4,
  parameter int BCID_W = 8,
  parameter int L1ID_W = 5,
  parameter int SUB_W  = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    L1Trig_In,
  input  logic [BCID_W-1:0]       BCID_In,
  output logic                    L1_Reg_Full,
  output logic                    L1_Reg_Empty,
  output logic [$clog2(DEPTH):0]  Occupancy,
  output logic                    Rd_Valid,
  input  logic                    Rd_Ack,
  output logic [L1ID_W-1:0]       Rd_L1ID,
  output logic [SUB_W-1:0]        Rd_Sub,
  output logic [BCID_W-1:0]       Rd_BCID,
  output logic                    Overflow_Err,
  input  logic                    Err_Clear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = L1ID_W + SUB_W + BCID_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Three copies of every control register
  logic [2:0][PTR_W-1:0]  wptr_q, rptr_q;
  logic [2:0][CNT_W-1:0]  cnt_q;
  logic [2:0][L1ID_W-1:0] next_id_q, cur_id_q;
  logic [2:0][SUB_W-1:0]  cur_sub_q;
  logic [2:0]             prev_q, ovf_q;

  // Majority-voted views
  logic [PTR_W-1:0]  wptr_v, rptr_v;
  logic [CNT_W-1:0]  cnt_v;
  logic [L1ID_W-1:0] next_id_v, cur_id_v;
  logic [SUB_W-1:0]  cur_sub_v;
  logic              prev_v, ovf_v;

  // Next-state values, loaded identically into all three copies
  logic [PTR_W-1:0]  wptr_d, rptr_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [L1ID_W-1:0] next_id_d, cur_id_d;
  logic [SUB_W-1:0]  cur_sub_d;
  logic              prev_d, ovf_d;

  logic              start, full, empty, push, pop, drop;
  logic [L1ID_W-1:0] tag_id;
  logic [SUB_W-1:0]  tag_sub;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  head;

  assign wptr_v    = (wptr_q[0] & wptr_q[1]) | (wptr_q[0] & wptr_q[2]) | (wptr_q[1] & wptr_q[2]);
  assign rptr_v    = (rptr_q[0] & rptr_q[1]) | (rptr_q[0] & rptr_q[2]) | (rptr_q[1] & rptr_q[2]);
  assign cnt_v     = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
  assign next_id_v = (next_id_q[0] & next_id_q[1]) | (next_id_q[0] & next_id_q[2]) | (next_id_q[1] & next_id_q[2]);
  assign cur_id_v  = (cur_id_q[0] & cur_id_q[1]) | (cur_id_q[0] & cur_id_q[2]) | (cur_id_q[1] & cur_id_q[2]);
  assign cur_sub_v = (cur_sub_q[0] & cur_sub_q[1]) | (cur_sub_q[0] & cur_sub_q[2]) | (cur_sub_q[1] & cur_sub_q[2]);
  assign prev_v    = (prev_q[0] & prev_q[1]) | (prev_q[0] & prev_q[2]) | (prev_q[1] & prev_q[2]);
  assign ovf_v     = (ovf_q[0] & ovf_q[1]) | (ovf_q[0] & ovf_q[2]) | (ovf_q[1] & ovf_q[2]);

  // Burst tagging, push/pop/drop decisions and next-state for all control
  always_comb begin
    start     = L1Trig_In & ~prev_v;
    full      = (cnt_v == FULL_CNT);
    empty     = (cnt_v == '0);
    // Full is judged on the pre-edge count, so a same-cycle pop cannot save a trigger
    push      = L1Trig_In & ~full;
    drop      = L1Trig_In & full;
    pop       = Rd_Ack & ~empty;
    tag_id    = start ? next_id_v : cur_id_v;
    tag_sub   = start ? '0 : cur_sub_v + SUB_W'(1);
    wptr_d    = push ? wptr_v + PTR_W'(1) : wptr_v;
    rptr_d    = pop  ? rptr_v + PTR_W'(1) : rptr_v;
    cnt_d     = cnt_v;
    case ({push, pop})
      2'b10:   cnt_d = cnt_v + CNT_W'(1);
      2'b01:   cnt_d = cnt_v - CNT_W'(1);
      default: cnt_d = cnt_v;
    endcase
    // ID and sub counters advance on dropped triggers too, leaving a visible gap
    next_id_d = start ? next_id_v + L1ID_W'(1) : next_id_v;
    cur_id_d  = start ? next_id_v : cur_id_v;
    cur_sub_d = L1Trig_In ? tag_sub : cur_sub_v;
    prev_d    = L1Trig_In;
    // A drop in the same cycle as a clear keeps the error set
    ovf_d     = drop | (ovf_v & ~Err_Clear);
  end

  // Control registers: every copy reloads from the voted next state, scrubbing upsets
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      next_id_q <= '0;
      cur_id_q  <= '0;
      cur_sub_q <= '0;
      prev_q    <= '0;
      ovf_q     <= '0;
    end else begin
      wptr_q    <= {3{wptr_d}};
      rptr_q    <= {3{rptr_d}};
      cnt_q     <= {3{cnt_d}};
      next_id_q <= {3{next_id_d}};
      cur_id_q  <= {3{cur_id_d}};
      cur_sub_q <= {3{cur_sub_d}};
      prev_q    <= {3{prev_d}};
      ovf_q     <= {3{ovf_d}};
    end
  end

  // Entry storage: written on accepted triggers only
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wptr_v] <= {tag_id, tag_sub, BCID_In};
    end
  end

  assign head         = mem_q[rptr_v];
  assign L1_Reg_Full  = full;
  assign L1_Reg_Empty = empty;
  assign Occupancy    = cnt_v;
  assign Rd_Valid     = ~empty;
  assign Overflow_Err = ovf_v;
  // Head fields are forced to zero whenever nothing valid is presented
  assign Rd_L1ID      = Rd_Valid ? head[ENT_W-1 -: L1ID_W]  : '0;
  assign Rd_Sub       = Rd_Valid ? head[BCID_W +: SUB_W]     : '0;
  assign Rd_BCID      = Rd_Valid ? head[BCID_W-1:0]          : '0;

endmodule

// File: tb/tb_l1_trigger_queue.sv
// Directed bench for l1_trigger_queue (default parameters: DEPTH=4,
// BCID_W=8, L1ID_W=5, SUB_W=4). Inputs change 1 ns after each rising edge;
// outputs are checked at that same point.
module tb_l1_trigger_queue;

  logic       Clk, Reset, L1Trig_In, Rd_Ack, Err_Clear;
  logic [7:0] BCID_In;
  logic       L1_Reg_Full, L1_Reg_Empty, Rd_Valid, Overflow_Err;
  logic [2:0] Occupancy;
  logic [4:0] Rd_L1ID;
  logic [3:0] Rd_Sub;
  logic [7:0] Rd_BCID;

  int n_vec = 0;
  int n_bad = 0;

  logic [2:0][1:0] wq;
  logic [2:0][4:0] nq;

  l1_trigger_queue dut (
    .Clk(Clk), .Reset(Reset), .L1Trig_In(L1Trig_In), .BCID_In(BCID_In),
    .L1_Reg_Full(L1_Reg_Full), .L1_Reg_Empty(L1_Reg_Empty), .Occupancy(Occupancy),
    .Rd_Valid(Rd_Valid), .Rd_Ack(Rd_Ack), .Rd_L1ID(Rd_L1ID), .Rd_Sub(Rd_Sub),
    .Rd_BCID(Rd_BCID), .Overflow_Err(Overflow_Err), .Err_Clear(Err_Clear)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int v, input int f, input int occ, input int ovf);
    chk({tag, ".valid"}, 32'(Rd_Valid), v);
    chk({tag, ".empty"}, 32'(L1_Reg_Empty), (v == 0) ? 1 : 0);
    chk({tag, ".full"},  32'(L1_Reg_Full), f);
    chk({tag, ".occ"},   32'(Occupancy), occ);
    chk({tag, ".ovf"},   32'(Overflow_Err), ovf);
  endtask

  task automatic chk_head(input string tag, input int id, input int sub, input int bcid);
    chk({tag, ".l1id"}, 32'(Rd_L1ID), id);
    chk({tag, ".sub"},  32'(Rd_Sub), sub);
    chk({tag, ".bcid"}, 32'(Rd_BCID), bcid);
  endtask

  task automatic pop_expect(input string tag, input int id, input int sub, input int bcid);
    chk_head(tag, id, sub, bcid);
    Rd_Ack = 1'b1;
    tick();
    Rd_Ack = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; L1Trig_In = 1'b0; BCID_In = 8'h00; Rd_Ack = 1'b0; Err_Clear = 1'b0;
    #12;
    chk_state("reset", 0, 0, 0, 0);
    chk_head("reset", 0, 0, 0);
    Reset = 1'b1;

    // Single trigger, then pop, then ack on an empty queue
    L1Trig_In = 1'b1; BCID_In = 8'h10; tick(); L1Trig_In = 1'b0;
    chk_state("single", 1, 0, 1, 0);
    chk_head("single", 0, 0, 8'h10);
    Rd_Ack = 1'b1; tick();
    chk_state("single_pop", 0, 0, 0, 0);
    tick();
    chk_state("ack_empty", 0, 0, 0, 0);
    chk_head("ack_empty", 0, 0, 0);
    Rd_Ack = 1'b0;

    // 3-cycle burst, gap, 1-cycle trigger: fills the queue exactly
    for (int i = 0; i < 3; i++) begin
      L1Trig_In = 1'b1; BCID_In = 8'(32'h20 + i); tick();
    end
    L1Trig_In = 1'b0; tick();
    L1Trig_In = 1'b1; BCID_In = 8'h30; tick(); L1Trig_In = 1'b0;
    chk_state("burst_full", 1, 1, 4, 0);
    pop_expect("burst_e0", 1, 0, 8'h20);
    chk_state("full_falls", 1, 0, 3, 0);
    pop_expect("burst_e1", 1, 1, 8'h21);
    pop_expect("burst_e2", 1, 2, 8'h22);
    pop_expect("burst_e3", 2, 0, 8'h30);
    chk_state("burst_drained", 0, 0, 0, 0);

    // 6-cycle burst with no reads: last two dropped
    for (int i = 0; i < 6; i++) begin
      L1Trig_In = 1'b1; BCID_In = 8'(32'h40 + i); tick();
      if (i == 3) chk_state("ovf_full4", 1, 1, 4, 0);
    end
    L1Trig_In = 1'b0;
    chk_state("ovf_set", 1, 1, 4, 1);
    for (int i = 0; i < 4; i++) pop_expect("ovf_pop", 3, i, 32'h40 + i);
    chk_state("ovf_sticky", 0, 0, 0, 1);
    Err_Clear = 1'b1; tick(); Err_Clear = 1'b0;
    chk_state("ovf_clear", 0, 0, 0, 0);
    L1Trig_In = 1'b1; BCID_In = 8'h50; tick(); L1Trig_In = 1'b0;
    chk_head("after_ovf", 4, 0, 8'h50);
    Rd_Ack = 1'b1; tick(); Rd_Ack = 1'b0;

    // Drop with simultaneous pop and clear: drop still happens, set wins
    for (int i = 0; i < 4; i++) begin
      L1Trig_In = 1'b1; BCID_In = 8'(32'h60 + i); tick();
    end
    chk_state("sw_full", 1, 1, 4, 0);
    BCID_In = 8'h64; Rd_Ack = 1'b1; Err_Clear = 1'b1; tick();
    Rd_Ack = 1'b0; Err_Clear = 1'b0;
    chk_state("sw_drop_pop", 1, 0, 3, 1);
    BCID_In = 8'h65; tick(); L1Trig_In = 1'b0;
    chk_state("sw_refill", 1, 1, 4, 1);
    pop_expect("sw_e1", 5, 1, 8'h61);
    pop_expect("sw_e2", 5, 2, 8'h62);
    pop_expect("sw_e3", 5, 3, 8'h63);
    pop_expect("sw_gap", 5, 5, 8'h65);
    Err_Clear = 1'b1; tick(); Err_Clear = 1'b0;
    chk_state("sw_done", 0, 0, 0, 0);

    // Push and pop every cycle at occupancy 1; sub index wraps at 16
    L1Trig_In = 1'b1; BCID_In = 8'h00; tick();
    Rd_Ack = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      BCID_In = 8'(i); tick();
      chk("stream.occ", 32'(Occupancy), 1);
      chk_head("stream", 6, i % 16, i);
    end
    L1Trig_In = 1'b0; tick(); Rd_Ack = 1'b0;
    chk_state("stream_done", 0, 0, 0, 0);

    // 40 single-cycle bursts: L1 ID wraps 31 -> 0
    for (int k = 0; k < 40; k++) begin
      L1Trig_In = 1'b1; BCID_In = 8'(k); tick(); L1Trig_In = 1'b0;
      chk_head("wrap", (7 + k) % 32, 0, k);
      Rd_Ack = 1'b1; tick(); Rd_Ack = 1'b0;
    end

    // Asynchronous reset mid-burst with three entries queued
    for (int i = 0; i < 3; i++) begin
      L1Trig_In = 1'b1; BCID_In = 8'(32'h80 + i); tick();
    end
    chk_state("pre_rst", 1, 0, 3, 0);
    #3 Reset = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 0, 0);
    chk_head("async_rst", 0, 0, 0);
    L1Trig_In = 1'b0;
    #1 Reset = 1'b1;
    tick();
    L1Trig_In = 1'b1; BCID_In = 8'h90; tick(); L1Trig_In = 1'b0;
    chk_state("post_rst", 1, 0, 1, 0);
    chk_head("post_rst", 0, 0, 8'h90);
    tick();

    // Corrupt one copy of the write pointer and of Next_ID
    wq[0] = 2'd1; wq[1] = 2'd2; wq[2] = 2'd1;
    nq[0] = 5'd1; nq[1] = 5'd1; nq[2] = 5'h1e;
    force dut.wptr_q = wq;
    force dut.next_id_q = nq;
    #1;
    release dut.wptr_q;
    release dut.next_id_q;
    #1;
    chk_state("seu", 1, 0, 1, 0);
    chk_head("seu", 0, 0, 8'h90);
    L1Trig_In = 1'b1; BCID_In = 8'hA0; tick(); L1Trig_In = 1'b0;
    chk("seu.wptr_copy1", 32'(dut.wptr_q[1]), 2);
    chk("seu.nextid_copy2", 32'(dut.next_id_q[2]), 2);
    chk_state("seu_push", 1, 0, 2, 0);
    pop_expect("seu_e0", 0, 0, 8'h90);
    chk_head("seu_e1", 1, 0, 8'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
